// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds or subtracts two WIDTH-bit operands DIGIT bits per
// clock, least-significant digit first. The digit carry is held in a register
// between cycles, so the carry chain is only DIGIT bits long.
// The start/busy/done handshake lets a new operation be accepted in the DONE
// cycle, so operations can run back-to-back.

module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   digit_result;
    logic [WIDTH-1:0] work_next;
    logic             msb_cin;

    // The operand registers shift right one digit per cycle, so the current
    // digit always sits in the low DIGIT bits. Result digits enter at the top
    // of the working register and reach their final position after N cycles.
    // The carry into the MSB follows from the MSB's inputs and its sum bit.
    always_comb begin
        digit_result = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry};
        work_next    = (work >> DIGIT)
                     | (WIDTH'(digit_result[DIGIT-1:0]) << (WIDTH - DIGIT));
        msb_cin      = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ digit_result[DIGIT-1];
    end

    // Control FSM and datapath registers. busy and done are registered
    // alongside the state, and the result registers load only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    work  <= work_next;
                    carry <= digit_result[DIGIT];
                    if (cnt == LAST) begin
                        sum   <= work_next;
                        cout  <= digit_result[DIGIT];
                        ovf   <= msb_cin ^ digit_result[DIGIT];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt   <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised, multi-cycle successor to the team's 4-bit combinational ripple adder. Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, least-significant digit first, and carries the digit carry in a register between cycles. It trades latency for a narrow carry chain in wide datapaths. A start/busy/done handshake lets a controller or testbench issue operations back-to-back.

## Interface

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits added per cycle; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT is the number of digit cycles.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b+cin; 1 = a−b, computed as a+~b+1 (cin ignored).
- a  input  WIDTH  operand A, captured on the accepted start.
- b  input  WIDTH  operand B, captured on the accepted start.
- cin  input  1  carry-in for add, captured on the accepted start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse; result valid from this cycle on.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of the MSB; for sub, 1 = no borrow.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation

- FSM states:
  - IDLE: start=1 → RUN.
  - RUN: stays N cycles, then → DONE.
  - DONE: lasts one cycle; start=1 → RUN, else → IDLE.
- On the accepted start:
  - Latch a, and b or ~b when sub=1.
  - Set the carry register to cin, or 1 when sub=1.
  - Clear the digit counter.
- Each RUN cycle:
  - Add digit k of A, digit k of B' and the carry register.
  - Write the DIGIT-bit result into digit k of the working register.
  - Store the carry-out in the carry register; increment k.
  - On the last digit, also record the carry into the MSB, used for ovf.
- Entering DONE: copy the working register to sum, the final carry to cout, and the MSB carry-in XOR carry-out to ovf.
- sum, cout and ovf change only on entry to DONE. They hold until the next DONE.
- Result is modulo 2^WIDTH. {cout,sum} must equal the (WIDTH+1)-bit value a+b+cin for add, and a+(2^WIDTH−1−b)+1 for sub.
- start in RUN is ignored; the operands in flight are unaffected.
- Inputs a, b, cin and sub may change freely after the start cycle.

## Timing

- Reset (async assert, synchronous release): state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; counter and carry register cleared.
- Cycle numbering: start sampled high at edge 0.
  - busy=1 during cycles 1..N.
  - done=1 during cycle N+1 only, with sum/cout/ovf valid.
- Latency: N+1 cycles from start to done.
- Throughput: one result per N+1 cycles when start is held high, because start is accepted in DONE.
- busy and done are never high together. busy is low in IDLE and DONE.
- DIGIT=WIDTH (N=1): busy for one cycle, done at cycle 2.
- rst asserted mid-RUN: aborts immediately; no done pulse; outputs return to reset values.
- Counter wrap-around must not occur: the counter is ⌈log2 N⌉ bits, minimum 1, and is cleared on the accepted start.

## Test plan

- WIDTH=16, DIGIT=4; a=0x0000, b=0x0002, cin=0, sub=0 → done at cycle 5; sum=0x0002, cout=0, ovf=0; busy high for cycles 1–4.
- a=0xFFFF, b=0xFFFF, cin=1, add → sum=0xFFFF, cout=1, ovf=0. Then a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
- sub=1: a=0x0005, b=0x0007, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Hold start=1 with new operands every cycle:
  - Operand changes during RUN do not alter the result.
  - A second operation is accepted in the DONE cycle; done pulses at cycles 5 and 10.
- Start an operation, assert rst at cycle 2 → busy=0 and sum=0 immediately, no done pulse. After release, a fresh operation completes correctly.
- Re-run with DIGIT=1 (N=16) and DIGIT=16 (N=1) against 1000 random vectors, comparing {cout,sum} to the reference model; latencies are 17 and 2 cycles.
